// File: rtl/lmfe_pkg.sv
// Shared types and helpers for the local-median-filter rank engine.
package lmfe_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INS  = 2'd1,
        OP_REP  = 2'd2
    } op_e;

    // All-ones value of a dw-bit sample; also marks unoccupied cells.
    function automatic logic [63:0] sentinel(input int dw);
        return (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    endfunction

    function automatic int med_idx(input int cnt);
        return (cnt - 1) >> 1;
    endfunction

endpackage

// File: rtl/lmfe_rank_cell.sv
// One cell of the systolic sorted window: holds a sample and computes its
// next value from its neighbours for insert or replace.
module lmfe_rank_cell
    import lmfe_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          i_clear,
    input  op_e           i_op,
    input  logic [DW-1:0] i_ins,
    input  logic [DW-1:0] i_del,
    input  logic [DW-1:0] i_pre,
    input  logic [DW-1:0] i_nxt,
    output logic [DW-1:0] o_cell
);

    localparam logic [DW-1:0] SENTINEL = DW'(sentinel(DW));

    logic [DW-1:0] r_cell;
    logic [DW-1:0] w_next;

    always_comb begin
        w_next = r_cell;
        if (i_clear) begin
            w_next = SENTINEL;
        end else begin
            case (i_op)
                // Strict compare places a new sample above existing equals.
                OP_INS: begin
                    if (r_cell > i_ins)
                        w_next = (i_pre > i_ins) ? i_pre : i_ins;
                end
                OP_REP: begin
                    if (i_ins < i_del) begin
                        if (r_cell > i_ins && r_cell <= i_del)
                            w_next = (i_pre > i_ins) ? i_pre : i_ins;
                    end else if (i_ins > i_del) begin
                        if (r_cell >= i_del && r_cell < i_ins)
                            w_next = (i_nxt < i_ins) ? i_nxt : i_ins;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) r_cell <= SENTINEL;
        else     r_cell <= w_next;
    end

    assign o_cell = r_cell;

endmodule

// File: rtl/lmfe_rank_filter.sv
// Running-rank engine: input register, sorted cell array update, then
// registered median/min/max/rank outputs.
module lmfe_rank_filter
    import lmfe_pkg::*;
#(
    parameter int DW = 8,
    parameter int N  = 49,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          CLR,
    input  logic          IN_VLD,
    input  logic          DEL_VLD,
    input  logic [DW-1:0] INS,
    input  logic [DW-1:0] DEL,
    input  logic [CW-1:0] RANK,
    output logic          OUT_VLD,
    output logic [DW-1:0] MED,
    output logic [DW-1:0] MIN,
    output logic [DW-1:0] MAX,
    output logic [DW-1:0] RANK_OUT,
    output logic [CW-1:0] CNT,
    output logic          ERR
);

    localparam logic [DW-1:0] SENTINEL = DW'(sentinel(DW));

    logic          r_vld_s1, r_dv_s1;
    logic [DW-1:0] r_ins_s1, r_del_s1;
    logic          r_vld_s2, r_err_s2;
    logic [CW-1:0] r_cnt;

    logic [DW-1:0] w_cell [N];
    logic [DW-1:0] w_pre  [N];
    logic [DW-1:0] w_nxt  [N];
    logic          w_match, w_ins_ok, w_rep_ok, w_err;
    op_e           w_op;
    logic [CW-1:0] w_med_idx, w_top_idx;
    logic [DW-1:0] w_med, w_min, w_max, w_rank;

    for (genvar gi = 0; gi < N; gi++) begin : g_cell
        if (gi == 0) begin : g_pre_lo
            assign w_pre[gi] = '0;
        end else begin : g_pre
            assign w_pre[gi] = w_cell[gi-1];
        end
        if (gi == N - 1) begin : g_nxt_hi
            assign w_nxt[gi] = SENTINEL;
        end else begin : g_nxt
            assign w_nxt[gi] = w_cell[gi+1];
        end
        lmfe_rank_cell #(.DW(DW)) u_cell (
            .clk     (clk),
            .RST     (RST),
            .i_clear (CLR),
            .i_op    (w_op),
            .i_ins   (r_ins_s1),
            .i_del   (r_del_s1),
            .i_pre   (w_pre[gi]),
            .i_nxt   (w_nxt[gi]),
            .o_cell  (w_cell[gi])
        );
    end

    // Only occupied cells may match; SENTINEL is a legal data value.
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < N; i++)
            if (CW'(i) < r_cnt && w_cell[i] == r_del_s1) w_match = 1'b1;
    end

    assign w_ins_ok = r_vld_s1 & ~r_dv_s1 & (r_cnt < CW'(N));
    assign w_rep_ok = r_vld_s1 &  r_dv_s1 & (r_cnt != '0) & w_match;
    assign w_err    = r_vld_s1 & ~(w_ins_ok | w_rep_ok);
    assign w_op     = w_ins_ok ? OP_INS : (w_rep_ok ? OP_REP : OP_HOLD);

    assign w_med_idx = CW'(med_idx(int'(r_cnt)));
    assign w_top_idx = r_cnt - CW'(1);

    always_comb begin
        w_med  = SENTINEL;
        w_min  = SENTINEL;
        w_max  = SENTINEL;
        w_rank = SENTINEL;
        if (r_cnt != '0) begin
            w_min = w_cell[0];
            for (int i = 0; i < N; i++) begin
                if (CW'(i) == w_med_idx)                 w_med  = w_cell[i];
                if (CW'(i) == w_top_idx)                 w_max  = w_cell[i];
                if (CW'(i) == RANK && RANK < r_cnt)      w_rank = w_cell[i];
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_vld_s1 <= 1'b0;
            r_dv_s1  <= 1'b0;
            r_ins_s1 <= '0;
            r_del_s1 <= '0;
            r_vld_s2 <= 1'b0;
            r_err_s2 <= 1'b0;
            r_cnt    <= '0;
            OUT_VLD  <= 1'b0;
            ERR      <= 1'b0;
            MED      <= SENTINEL;
            MIN      <= SENTINEL;
            MAX      <= SENTINEL;
            RANK_OUT <= SENTINEL;
        end else if (CLR) begin
            // Drop in-flight work; result data registers keep their values.
            r_vld_s1 <= 1'b0;
            r_vld_s2 <= 1'b0;
            r_err_s2 <= 1'b0;
            r_cnt    <= '0;
            OUT_VLD  <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            r_vld_s1 <= IN_VLD;
            r_dv_s1  <= DEL_VLD;
            r_ins_s1 <= INS;
            r_del_s1 <= DEL;
            r_vld_s2 <= r_vld_s1;
            r_err_s2 <= w_err;
            if (w_op == OP_INS) r_cnt <= r_cnt + CW'(1);
            OUT_VLD  <= r_vld_s2;
            ERR      <= r_vld_s2 & r_err_s2;
            if (r_vld_s2) begin
                MED      <= w_med;
                MIN      <= w_min;
                MAX      <= w_max;
                RANK_OUT <= w_rank;
            end
        end
    end

    assign CNT = r_cnt;

endmodule

// File: tb/tb_lmfe_rank_filter.sv
// Scoreboard bench for lmfe_rank_filter with N = 5, DW = 8.
module tb_lmfe_rank_filter;

    localparam int DW = 8;
    localparam int N  = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic          CLR = 1'b0;
    logic          IN_VLD = 1'b0;
    logic          DEL_VLD = 1'b0;
    logic [DW-1:0] INS = '0;
    logic [DW-1:0] DEL = '0;
    logic [CW-1:0] RANK = 3'd4;
    logic          OUT_VLD, ERR;
    logic [DW-1:0] MED, MIN, MAX, RANK_OUT;
    logic [CW-1:0] CNT;

    lmfe_rank_filter #(.DW(DW), .N(N)) dut (
        .clk(clk), .RST(RST), .CLR(CLR), .IN_VLD(IN_VLD), .DEL_VLD(DEL_VLD),
        .INS(INS), .DEL(DEL), .RANK(RANK), .OUT_VLD(OUT_VLD), .MED(MED),
        .MIN(MIN), .MAX(MAX), .RANK_OUT(RANK_OUT), .CNT(CNT), .ERR(ERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          err;
        logic [DW-1:0] med, mn, mx, ro;
        int            cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Operation accepted at the next edge (E0); result expected after E2.
    task automatic issue(input logic [DW-1:0] ins, input logic [DW-1:0] del,
                         input logic dv, input logic xerr,
                         input logic [DW-1:0] xmed, input logic [DW-1:0] xmin,
                         input logic [DW-1:0] xmax, input logic [DW-1:0] xro);
        exp_t x;
        @(negedge clk);
        CLR = 1'b0; IN_VLD = 1'b1; DEL_VLD = dv; INS = ins; DEL = del;
        x.err = xerr; x.med = xmed; x.mn = xmin; x.mx = xmax; x.ro = xro;
        x.cyc = cyc + 3;
        q.push_back(x);
    endtask

    task automatic drain();
        @(negedge clk);
        IN_VLD = 1'b0; DEL_VLD = 1'b0; CLR = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (OUT_VLD === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_vld", int'(OUT_VLD), 0);
                end else begin
                    e = q.pop_front();
                    chk("err",      int'(ERR),      int'(e.err));
                    chk("med",      int'(MED),      int'(e.med));
                    chk("min",      int'(MIN),      int'(e.mn));
                    chk("max",      int'(MAX),      int'(e.mx));
                    chk("rank_out", int'(RANK_OUT), int'(e.ro));
                    chk("latency",  cyc,            e.cyc);
                end
            end else if (ERR === 1'b1) begin
                chk("err_without_vld", int'(ERR), 0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        chk("rst_cnt",     int'(CNT),      0);
        chk("rst_med",     int'(MED),      'hFF);
        chk("rst_min",     int'(MIN),      'hFF);
        chk("rst_max",     int'(MAX),      'hFF);
        chk("rst_rank",    int'(RANK_OUT), 'hFF);
        chk("rst_out_vld", int'(OUT_VLD),  0);
        chk("rst_err",     int'(ERR),      0);

        // Fill back-to-back; RANK = 4 throughout.
        issue(8'd30, 8'd0, 1'b0, 1'b0, 8'd30, 8'd30, 8'd30, 8'hFF);
        issue(8'd10, 8'd0, 1'b0, 1'b0, 8'd10, 8'd10, 8'd30, 8'hFF);
        issue(8'd50, 8'd0, 1'b0, 1'b0, 8'd30, 8'd10, 8'd50, 8'hFF);
        issue(8'd20, 8'd0, 1'b0, 1'b0, 8'd20, 8'd10, 8'd50, 8'hFF);
        issue(8'd40, 8'd0, 1'b0, 1'b0, 8'd30, 8'd10, 8'd50, 8'd50);
        drain();
        chk("fill_cnt", int'(CNT), 5);

        // Replace up, replace down, then two rejected operations.
        issue(8'd60, 8'd10, 1'b1, 1'b0, 8'd40, 8'd20, 8'd60, 8'd60);
        issue(8'd5,  8'd60, 1'b1, 1'b0, 8'd30, 8'd5,  8'd50, 8'd50);
        issue(8'd70, 8'd0,  1'b0, 1'b1, 8'd30, 8'd5,  8'd50, 8'd50);
        issue(8'd1,  8'd99, 1'b1, 1'b1, 8'd30, 8'd5,  8'd50, 8'd50);
        drain();
        chk("err_cnt", int'(CNT), 5);

        // Duplicates: only one 7 is removed.
        @(negedge clk); CLR = 1'b1;
        issue(8'd7, 8'd0, 1'b0, 1'b0, 8'd7, 8'd7, 8'd7, 8'hFF);
        issue(8'd7, 8'd0, 1'b0, 1'b0, 8'd7, 8'd7, 8'd7, 8'hFF);
        issue(8'd7, 8'd0, 1'b0, 1'b0, 8'd7, 8'd7, 8'd7, 8'hFF);
        issue(8'd7, 8'd0, 1'b0, 1'b0, 8'd7, 8'd7, 8'd7, 8'hFF);
        issue(8'd7, 8'd0, 1'b0, 1'b0, 8'd7, 8'd7, 8'd7, 8'd7);
        issue(8'd3, 8'd7, 1'b1, 1'b0, 8'd7, 8'd3, 8'd7, 8'd7);
        drain();
        chk("dup_cnt", int'(CNT), 5);

        // RST pulse while a (rejected) insert sits in stage 2.
        @(negedge clk); IN_VLD = 1'b1; DEL_VLD = 1'b0; INS = 8'd42;
        @(negedge clk); IN_VLD = 1'b0;
        @(negedge clk); RST = 1'b1;
        @(negedge clk); RST = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstab_cnt",     int'(CNT),      0);
        chk("rstab_med",     int'(MED),      'hFF);
        chk("rstab_min",     int'(MIN),      'hFF);
        chk("rstab_max",     int'(MAX),      'hFF);
        chk("rstab_rank",    int'(RANK_OUT), 'hFF);
        chk("rstab_out_vld", int'(OUT_VLD),  0);

        // SENTINEL as data, issued in the cycle right after CLR.
        issue(8'd9, 8'd0, 1'b0, 1'b0, 8'd9, 8'd9, 8'd9, 8'hFF);
        drain();
        @(negedge clk); CLR = 1'b1;
        issue(8'hFF, 8'd0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        drain();
        chk("ff_cnt", int'(CNT), 1);

        // In-flight insert aborted by CLR on the next cycle.
        @(negedge clk); IN_VLD = 1'b1; DEL_VLD = 1'b0; INS = 8'd42;
        @(negedge clk); IN_VLD = 1'b0; CLR = 1'b1;
        @(negedge clk); CLR = 1'b0;
        repeat (4) @(negedge clk);
        chk("clrab_cnt", int'(CNT), 0);
        chk("clrab_med_hold", int'(MED), 'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lmfe_rank_filter.md
Name: lmfe_rank_filter

Overview:
- Parametrised running-rank engine for the local median filter datapath.
- Holds a sorted window of up to N samples as a systolic insertion array.
- Supports three operations:
  - insert-only, for window fill at row/frame start;
  - replace, which inserts one sample and deletes another in the same cycle;
  - clear.
- Reports the median, min, max and a programmable rank of the valid entries, with valid and error flags. Sits between the window line buffers and the output pixel pipeline.

Parameters:
DW, 8, sample width in bits
N, 49, window depth in cells; odd, 3..255
CW, $clog2(N+1), occupancy/rank width

Ports:
clk  in  1  clock
RST  in  1  reset, asynchronous, active-high
CLR  in  1  synchronous clear of window and pipeline
IN_VLD  in  1  operation strobe
DEL_VLD  in  1  with IN_VLD: 1 = replace, 0 = insert-only
INS  in  DW  sample to insert
DEL  in  DW  sample to delete (replace only)
RANK  in  CW  rank select, 0 = smallest
OUT_VLD  out  1  one-cycle pulse; result registers updated
MED  out  DW  median of valid entries
MIN  out  DW  smallest valid entry
MAX  out  DW  largest valid entry
RANK_OUT  out  DW  entry at index RANK
CNT  out  CW  occupancy, 0..N
ERR  out  1  one-cycle pulse with OUT_VLD: operation rejected

Behaviour:
- Reset (RST high):
  - every cell = SENTINEL (all ones); CNT = 0; pipeline valid = 0;
  - OUT_VLD = 0, ERR = 0; MED, MIN, MAX, RANK_OUT = SENTINEL.
- Invariants:
  - cells 0..N-1 are non-decreasing;
  - valid entries occupy indices 0..CNT-1; all cells at or above CNT hold SENTINEL.
- Stage 1 (edge E1 after IN_VLD is sampled) updates the array in parallel. Each cell sees its own value c, its lower neighbour PRE (0 for cell 0) and its upper neighbour NXT (SENTINEL above cell N-1).
- Insert-only (DEL_VLD = 0):
  - accepted only if CNT < N;
  - cells with c > INS take max(PRE, INS); other cells hold;
  - equal values: the new sample goes above existing equals;
  - CNT increments.
- Replace with INS < DEL: cells with INS < c <= DEL take PRE if PRE > INS, else INS.
- Replace with INS > DEL: cells with DEL <= c < INS take NXT if NXT < INS, else INS.
- Replace with INS == DEL: no change.
- Replace never changes CNT. Exactly one instance of DEL is removed when duplicates exist.
- Replace is accepted only if CNT >= 1 and some valid cell equals DEL. The match check is combinational in stage 1.
- Rejected operations (insert when CNT == N, or DEL not present):
  - array and CNT unchanged;
  - stage-1 valid still set, and ERR pulses together with OUT_VLD.
- Stage 2 (edge E2) registers:
  - MED = cell[(CNT-1)>>1];
  - MIN = cell[0];
  - MAX = cell[CNT-1];
  - RANK_OUT = cell[RANK] if RANK < CNT, else SENTINEL;
  - if CNT == 0, all four outputs = SENTINEL.
- OUT_VLD is high for the cycle after E2. Latency: IN_VLD sampled at E0 gives OUT_VLD at E2. Throughput is one operation per cycle.
- RANK is sampled at stage 2, not at issue.
- CLR:
  - has priority over IN_VLD in the same cycle;
  - next edge: cells = SENTINEL, CNT = 0, both pipeline valids cleared;
  - an in-flight result is dropped (no OUT_VLD); output data registers hold their values.
- RST asserted mid-operation: same as CLR, but asynchronous, and outputs return to their reset values.
- SENTINEL is also a legal data value. Validity is decided by CNT only, never by value.
- An IN_VLD in the cycle right after CLR is accepted normally.

Decomposition:
- Package lmfe_pkg holds:
  - the SENTINEL(DW) function or constant;
  - op enum OP_HOLD / OP_INS / OP_REP;
  - the median index function (CNT-1)>>1.
- One natural sub-module, lmfe_rank_cell (parametrised by DW):
  - inputs: INS, DEL, PRE, NXT, op, clear;
  - contains one cell register and its next-value logic.
- The top level contains:
  - the generate chain of N cells;
  - the DEL match OR-reduction;
  - the CNT counter;
  - the stage-2 output muxes and registers.

Test Plan:
All tests use N = 5, DW = 8.
- Reset → after RST release: CNT = 0, MED = MIN = MAX = 0xFF, OUT_VLD = 0, ERR = 0.
- Fill by inserting 30, 10, 50, 20, 40 back-to-back → successive MED = 30, 10, 30, 20, 30; CNT = 1..5; final MIN = 10, MAX = 50. Each OUT_VLD arrives 2 cycles after its IN_VLD.
- Replace INS = 60, DEL = 10 → array 20, 30, 40, 50, 60; MED = 40; with RANK = 4, RANK_OUT = 60. Then replace INS = 5, DEL = 60 → MED = 30, MIN = 5.
- Error cases:
  - insert 70 while CNT = 5 → ERR pulse, MED unchanged, CNT = 5;
  - replace DEL = 99 (absent) → ERR pulse, array unchanged.
- Duplicates: fill with five 7s, then replace INS = 3, DEL = 7 → array 3, 7, 7, 7, 7, MED = 7. Then insert 0xFF as data after a CLR → CNT = 1, MED = 0xFF, MAX = 0xFF.
- Abort cases:
  - IN_VLD, then CLR the next cycle → no OUT_VLD, CNT = 0;
  - RST pulse during stage 2 → OUT_VLD stays 0 and all outputs return to reset values.
